// File: rtl/instr_issue_sequencer.sv
// -----------------------------------------------------------------------------
// instr_issue_sequencer
//
// This block supplies instructions to the CompALU datapath. It holds a short
// program in an internal instruction memory. After start, it issues one R-type
// word per accepted cycle on Instruction, using a valid/stall handshake.
// Issuing ends on the first HALT_WORD, which is never issued, or after the last
// memory word. Self-running builds use this block in place of file-driven
// stimulus.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset (memory contents are kept)
//   load_en      write load_data to mem[load_addr]; honoured only in IDLE
//   load_addr    program load address
//   load_data    program load word
//   start        level; begin issuing from address 0 (sampled in IDLE)
//   stall        consumer is not accepting the current Instruction
//   Instruction  registered instruction word to CompALU
//   instr_valid  Instruction holds a real word that has not been accepted
//   pc           memory address of the word on Instruction
//   done         program finished (halt word or end of memory)
// -----------------------------------------------------------------------------
module instr_issue_sequencer #(
  parameter int                     ADDR_WIDTH  = 6,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = {INSTR_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  // The fetch pointer is one bit wider than the address. Its top bit marks
  // that fetching has gone past the last word, so the pointer never wraps.
  logic [ADDR_WIDTH:0]      fp_q, fp_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic                     done_q, done_d;

  logic [INSTR_WIDTH-1:0]   mem_q [DEPTH];
  logic                     mem_we;
  logic [INSTR_WIDTH-1:0]   mem_rd;
  logic                     at_end;
  logic                     advance;

  // The program can only be written while the sequencer is idle. This stops a
  // load from corrupting a program that is still being issued.
  assign mem_we  = load_en && (state_q == S_IDLE);
  assign mem_rd  = mem_q[fp_q[ADDR_WIDTH-1:0]];
  assign at_end  = fp_q[ADDR_WIDTH];
  // The sequencer moves to the next word only when no word is being shown, or
  // when the consumer accepts the current word. A stall with nothing valid on
  // the output is ignored.
  assign advance = !valid_q || !stall;

  // NOTE: the memory has no reset branch. That keeps it a plain RAM, and the
  // loaded program survives rst so a restart can reissue it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // NOTE: every target gets a default value before the case statement. This
  // way no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          fp_d    = '0;
        end
      end

      S_RUN: begin
        if (advance) begin
          if (at_end || (mem_rd == HALT_WORD)) begin
            // The halt word itself is never put on Instruction.
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            instr_d = mem_rd;
            pc_d    = fp_q[ADDR_WIDTH-1:0];
            valid_d = 1'b1;
            fp_d    = fp_q + (ADDR_WIDTH+1)'(1);
          end
        end
      end

      S_DONE: begin
        // Stay here until start is dropped. A held start therefore cannot
        // re-launch the program straight away.
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // their next values together, so the order of the statements cannot change
  // the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fp_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_sequencer
//
// Self-checking bench for instr_issue_sequencer. The reference model works at
// program level. It derives the expected issue list from a copy of the memory:
// every word up to the first halt word, or up to the end of memory. It then
// replays the valid/stall handshake against that list, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_instr_issue_sequencer;

  localparam int          AW    = 6;
  localparam int          IW    = 32;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          start;
  logic          stall;
  logic [IW-1:0] Instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          done;

  instr_issue_sequencer #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .HALT_WORD  (HALT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .stall      (stall),
    .Instruction(Instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [31:0] mem_m [DEPTH];
  int          m_pos;
  bit          m_valid;
  bit          m_done;
  logic [31:0] m_instr;
  int          m_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] w);
    load_en   = 1'b1;
    load_addr = a[AW-1:0];
    load_data = w;
    @(posedge clk); #1;
    load_en   = 1'b0;
    mem_m[a]  = w;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    while (w === HALT) w = $urandom;
    return w;
  endfunction

  // Run the program now in memory.
  //   rand_mode  random stalls, plus ignored start/load_en activity during RUN
  //   stall_mask stall value per cycle after RUN entry (directed mode)
  //   poke       pulse load_en addr=1 data=0 during RUN
  //   abort_at   assert rst mid-cycle once this many words have transferred (-1 = never)
  task automatic run_prog(input bit rand_mode, input logic [31:0] stall_mask,
                          input bit poke, input int abort_at);
    logic [31:0] exp_w[$];
    int          xfers;
    bit          st;
    exp_w = {};
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_m[i] === HALT) break;
      exp_w.push_back(mem_m[i]);
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_entry_valid", instr_valid, 0);
    check("run_entry_done", done, 0);

    m_pos = 0; m_valid = 0; m_done = 0; xfers = 0;
    for (int c = 0; c < 2000 && !m_done; c++) begin
      st = rand_mode ? ($urandom_range(0, 2) == 0) : ((c < 32) ? stall_mask[c] : 1'b0);
      stall = st;
      if (rand_mode) begin
        start     = 1'($urandom_range(0, 1));
        load_en   = 1'($urandom_range(0, 1));
        load_addr = AW'($urandom);
        load_data = $urandom;
      end else begin
        load_en   = poke && (c == 1);
        load_addr = 6'd1;
        load_data = 32'h0;
      end
      @(posedge clk);
      // Handshake model. Move on when nothing is shown or the shown word is accepted.
      if (!m_valid || !st) begin
        if (m_valid) xfers++;
        if (m_pos == exp_w.size()) begin
          m_valid = 0;
          m_done  = 1;
        end else begin
          m_instr = exp_w[m_pos];
          m_pc    = m_pos;
          m_valid = 1;
          m_pos++;
        end
      end
      #1;
      check("cyc_valid", instr_valid, m_valid);
      check("cyc_done", done, m_done);
      check("cyc_instr", Instruction, m_instr);
      check("cyc_pc", pc, m_pc);

      if (abort_at >= 0 && xfers == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_instr", Instruction, 0);
        check("abort_valid", instr_valid, 0);
        check("abort_pc", pc, 0);
        check("abort_done", done, 0);
        load_en = 1'b0; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_instr = 0; m_pc = 0; m_valid = 0; m_done = 0;
        return;
      end
    end
    check("run_finished", m_done, 1);
    check("xfer_count", xfers, exp_w.size());

    // DONE: a held start keeps DONE, and load_en is ignored.
    start = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = 32'h0; stall = 1'b0;
    @(posedge clk); #1;
    load_en = 1'b0;
    check("done_hold_done", done, 1);
    check("done_hold_valid", instr_valid, 0);
    check("done_hold_pc", pc, m_pc);
    check("done_hold_instr", Instruction, m_instr);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_valid", instr_valid, 0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stall = 1'b0;
    m_instr = 0; m_pc = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

    // Reset takes effect before any clock edge.
    #2;
    check("rst_instr", Instruction, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: A,B,C then HALT, with no stalls.
    load_word(0, 32'h0123_4567);
    load_word(1, 32'h89AB_CDEF);
    load_word(2, 32'h0F1E_2D3C);
    load_word(3, HALT);
    run_prog(1'b0, 32'h0, 1'b0, -1);

    // Test 2: stall for three cycles while B is shown.
    run_prog(1'b0, 32'h0000_001C, 1'b0, -1);

    // Test 3: a load during RUN is ignored, so the re-run still issues B.
    run_prog(1'b0, 32'h0, 1'b1, -1);
    run_prog(1'b0, 32'h0, 1'b0, -1);

    // Test 4: full memory without a halt; issuing must not wrap past pc 63.
    for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
    run_prog(1'b0, 32'h0, 1'b0, -1);
    check("full_pc_last", pc, 63);

    // Test 5: halt at address 0.
    load_word(0, HALT);
    run_prog(1'b0, 32'h0, 1'b0, -1);

    // Test 6: reset after two issues, then restart from the retained memory.
    load_word(0, rand_word());
    run_prog(1'b0, 32'h0, 1'b0, 2);
    run_prog(1'b0, 32'h0, 1'b0, -1);

    // Random programs with random stalls.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) load_word(i, (i == len) ? HALT : rand_word());
      run_prog(1'b1, 32'h0, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
